serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that sequences a single `full_adder` instance over two WIDTH-bit operands, one bit per clock, LSB first, with a registered carry between bits. It sits between a requester that issues add operations and a consumer that takes the results. Both sides use valid/ready handshakes. The block trades throughput for area: one 1-bit adder cell serves any operand width.

---
 rtl/serial_adder_ctrl.sv | 117 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell walks two WIDTH-bit operands LSB first,
// carrying between bits in a flop, with valid/ready handshakes on both sides.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic [WIDTH-1:0] s_next_s;
    logic             carry_r;
    logic [CW-1:0]    count_r;
    logic             fa_sum_s;
    logic             fa_cout_s;

    full_adder u_fa (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Next sum shift value; written bitwise so WIDTH=1 needs no empty slice.
    always_comb begin
        s_next_s            = s_r >> 1;
        s_next_s[WIDTH-1]   = fa_sum_s;
    end

    // Sequencer: accept in IDLE, one bit per cycle in RUN, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            carry_r <= 1'b0;
            count_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        count_r <= '0;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_r     <= a_r >> 1;
                    b_r     <= b_r >> 1;
                    s_r     <= s_next_s;
                    carry_r <= fa_cout_s;
                    count_r <= count_r + ONE;
                    if (count_r == LAST_BIT) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from flops or the state register only.
    assign start_ready  = (state_r == ST_IDLE);
    assign result_valid = (state_r == ST_DONE);
    assign busy         = (state_r != ST_IDLE);
    assign sum          = s_r;
    assign cout         = carry_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 directed/random ops and a WIDTH=4
// back-to-back sweep, both checked every cycle against a timing/arithmetic model.

module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    logic       sv8, sr8, rv8, rr8, c8, cout8, busy8;
    logic [7:0] a8, b8, sum8;
    logic       sv4, sr4, rv4, rr4, c4, cout4, busy4;
    logic [3:0] a4, b4, sum4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
        .a(a8), .b(b8), .cin(c8), .result_valid(rv8), .result_ready(rr8),
        .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
        .a(a4), .b(b4), .cin(c4), .result_valid(rv4), .result_ready(rr4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int wd(input int u);
        return (u == 0) ? 8 : 4;
    endfunction

    // Model inputs gathered per unit (0: WIDTH=8, 1: WIDTH=4).
    int   in_a [2];
    int   in_b [2];
    logic in_c [2];
    logic in_sv[2];
    logic in_rr[2];
    always_comb begin
        in_a[0] = int'(a8);  in_b[0] = int'(b8);  in_c[0] = c8; in_sv[0] = sv8; in_rr[0] = rr8;
        in_a[1] = int'(a4);  in_b[1] = int'(b4);  in_c[1] = c4; in_sv[1] = sv4; in_rr[1] = rr4;
    end

    // Behavioural model: idle flag, cycles remaining until result, exact sum.
    bit m_idle[2];
    int m_rem [2];
    int m_res [2];
    int n_acc [2] = '{0, 0};
    int n_hs  [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                m_idle[u] <= 1'b1;
                m_rem[u]  <= 0;
                m_res[u]  <= 0;
            end else if (m_idle[u]) begin
                if (in_sv[u]) begin
                    m_idle[u] <= 1'b0;
                    m_rem[u]  <= wd(u);
                    m_res[u]  <= in_a[u] + in_b[u] + int'(in_c[u]);
                    n_acc[u]  <= n_acc[u] + 1;
                end
            end else if (m_rem[u] > 0) begin
                m_rem[u] <= m_rem[u] - 1;
            end else if (in_rr[u]) begin
                m_idle[u] <= 1'b1;
                n_hs[u]   <= n_hs[u] + 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            logic o_sr, o_rv, o_busy;
            int   o_val;
            o_sr   = (u == 0) ? sr8   : sr4;
            o_rv   = (u == 0) ? rv8   : rv4;
            o_busy = (u == 0) ? busy8 : busy4;
            o_val  = (u == 0) ? int'({cout8, sum8}) : int'({cout4, sum4});
            if (!rst_n) begin
                check($sformatf("rst_ready%0d", u), int'(o_sr), 1);
                check($sformatf("rst_valid%0d", u), int'(o_rv), 0);
                check($sformatf("rst_busy%0d", u), int'(o_busy), 0);
                check($sformatf("rst_sum%0d", u), o_val, 0);
            end else begin
                check($sformatf("m_ready%0d", u), int'(o_sr), int'(m_idle[u]));
                check($sformatf("m_valid%0d", u), int'(o_rv), int'(!m_idle[u] && m_rem[u] == 0));
                check($sformatf("m_busy%0d", u), int'(o_busy), int'(!m_idle[u]));
                if (!m_idle[u] && m_rem[u] == 0) begin
                    check($sformatf("m_sum%0d", u), o_val, m_res[u]);
                end
            end
        end
    end

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                       input int hold, input bit noisy,
                       output logic [7:0] rs, output logic rc, output int lat);
        int n;
        n = 0;
        while (!sr8 && n < 50) begin @(posedge clk); #1; n++; end
        check("wait_idle", int'(n < 50), 1);
        a8 = ta; b8 = tb2; c8 = tc; sv8 = 1'b1; rr8 = 1'b0;
        @(posedge clk); #1;
        sv8 = 1'b0;
        lat = 0;
        while (!rv8 && lat < 40) begin
            if (noisy) begin
                a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); sv8 = 1'b1;
                check("iso_ready", int'(sr8), 0);
            end
            @(posedge clk); #1;
            lat++;
        end
        sv8 = 1'b0;
        rs = sum8; rc = cout8;
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_result", int'({cout8, sum8}), int'({rc, rs}));
            check("hold_valid", int'(rv8), 1);
        end
        rr8 = 1'b1;
        @(posedge clk); #1;
        rr8 = 1'b0;
        check("idle_after_hs", int'(sr8), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    bit sweep_on = 1'b0;

    initial begin
        logic [7:0] rs, ta, tb2;
        logic       rc, tc;
        int         lat, n, base_acc, base_hs;
        logic [7:0] ca [3] = '{8'hFF, 8'hFF, 8'h00};
        logic [7:0] cb [3] = '{8'h01, 8'hFF, 8'h00};
        logic       cc [3] = '{1'b0, 1'b1, 1'b1};
        logic [8:0] ce [3] = '{9'h100, 9'h1FF, 9'h001};

        rst_n = 1'b0;
        sv8 = 1'b0; rr8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        sv4 = 1'b0; rr4 = 1'b0; a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", int'(sr8), 1);
        check("reset_sum", int'({cout8, sum8}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op8(8'h5A, 8'h3C, 1'b0, 0, 1'b0, rs, rc, lat);
        check("lat_5a3c", lat, 8);
        check("sum_5a3c", int'({rc, rs}), 9'h096);

        for (int i = 0; i < 3; i++) begin
            op8(ca[i], cb[i], cc[i], 0, 1'b0, rs, rc, lat);
            check($sformatf("carry_case%0d", i), int'({rc, rs}), int'(ce[i]));
        end

        op8(8'h77, 8'h99, 1'b1, 5, 1'b0, rs, rc, lat);
        check("backpressure", int'({rc, rs}), 9'h111);

        op8(8'h12, 8'h34, 1'b0, 0, 1'b1, rs, rc, lat);
        check("isolation", int'({rc, rs}), 9'h046);

        for (int i = 0; i < 20; i++) begin
            ta = 8'($urandom); tb2 = 8'($urandom); tc = 1'($urandom);
            op8(ta, tb2, tc, int'($urandom_range(0, 3)), 1'b0, rs, rc, lat);
            check("random8", int'({rc, rs}), int'(ta) + int'(tb2) + int'(tc));
            check("random8_lat", lat, 8);
        end

        // Reset in the middle of RUN; outputs must drop without a clock edge.
        a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1; sv8 = 1'b1;
        @(posedge clk); #1;
        sv8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ready", int'(sr8), 1);
        check("async_valid", int'(rv8), 0);
        check("async_busy", int'(busy8), 0);
        check("async_result", int'({cout8, sum8}), 0);
        #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op8(8'h80, 8'h80, 1'b0, 0, 1'b0, rs, rc, lat);
        check("after_reset", int'({rc, rs}), 9'h100);

        // WIDTH=4 exhaustive sweep with random result backpressure.
        base_acc = n_acc[1];
        base_hs  = n_hs[1];
        sweep_on = 1'b1;
        fork
            while (sweep_on) begin
                @(posedge clk); #1;
                rr4 = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int idx = 0; idx < 512; idx++) begin
            logic [8:0] v;
            v = 9'(idx);
            a4 = v[3:0]; b4 = v[7:4]; c4 = v[8]; sv4 = 1'b1;
            n = 0;
            while (!sr4 && n < 50) begin @(posedge clk); #1; n++; end
            check("sweep_accept", int'(n < 50), 1);
            @(posedge clk); #1;
        end
        sv4 = 1'b0;
        n = 0;
        while (busy4 && n < 100) begin @(posedge clk); #1; n++; end
        check("sweep_drain", int'(n < 100), 1);
        sweep_on = 1'b0;
        @(posedge clk); #1;
        check("sweep_accepts", n_acc[1] - base_acc, 512);
        check("sweep_handshakes", n_hs[1] - base_hs, 512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
